// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache responder with zero-latency hits.
// On a miss it runs a single blocking fill from memory, then replays the lookup in IDLE.
module icache_responder #(
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int NUM   = 1 << IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_q, state_d;
  logic [NUM-1:0]     valid_q, valid_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
  logic [TAG_W-1:0]   tag_q  [NUM];
  logic [31:0]        data_q [NUM];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic               lookup_hit;
  logic               fill_we;
  logic               unused_byte_offset;

  assign unused_byte_offset = ^imemaddr[1:0];

  always_comb begin
    req_idx      = imemaddr[IDX_W+1:2];
    req_tag      = imemaddr[31:IDX_W+2];
    fill_idx     = miss_addr_q[IDX_W+1:2];
    lookup_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    state_d      = state_q;
    valid_d      = valid_q;
    miss_addr_d  = miss_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    fill_we      = 1'b0;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = 32'h0;

    case (state_q)
      IDLE: begin
        // A flush in the same cycle masks the hit so stale data never escapes.
        ihit = imemREN && lookup_hit && !flush;
        if (ihit) imemload = data_q[req_idx];
        if (imemREN && !ihit) begin
          miss_addr_d  = {imemaddr[31:2], 2'b00};
          miss_count_d = miss_count_q + 32'd1;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (imemREN && ihit) hit_count_d = hit_count_q + 32'd1;
    // Flush is applied last so it beats a coincident fill completion.
    if (flush) valid_d = '0;

    if (RST) begin
      ihit     = 1'b0;
      imemload = 32'h0;
      iREN     = 1'b0;
      iaddr    = 32'h0;
      fill_we  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= 32'h0;
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= miss_addr_q[31:IDX_W+2];
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus randomized traffic, all checked
// against a word-addressed cache model with a single outstanding fill.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 CLK = ~CLK;

  icache_responder #(.IDX_W(4)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cache lines keyed by full word address.
  bit          m_pend;
  logic [29:0] m_paddr;
  bit          m_valid [16];
  logic [29:0] m_waddr [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  logic        last_ihit;
  logic [31:0] last_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ren, input logic [31:0] addr, input bit fl,
                      input bit iw, input logic [31:0] ld, input bit rs);
    logic [29:0] wa;
    int          ix;
    int          pix;
    bit          eh;
    bit          eren;
    logic [31:0] el;
    logic [31:0] ea;
    @(negedge CLK);
    RST = rs; imemREN = ren; imemaddr = addr; flush = fl; iwait = iw; iload = ld;
    #1;
    wa   = addr[31:2];
    ix   = int'(wa[3:0]);
    pix  = int'(m_paddr[3:0]);
    eh   = !rs && !m_pend && ren && !fl && m_valid[ix] && (m_waddr[ix] == wa);
    el   = eh ? m_data[ix] : 32'h0;
    eren = !rs && m_pend;
    ea   = eren ? {m_paddr, 2'b00} : 32'h0;
    last_ihit = ihit;
    last_load = imemload;
    check("ihit",       {31'b0, ihit}, {31'b0, eh});
    check("imemload",   imemload, el);
    check("iREN",       {31'b0, iREN}, {31'b0, eren});
    check("iaddr",      iaddr, ea);
    check("hit_count",  hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
    @(posedge CLK);
    if (rs) begin
      m_pend = 0; m_hits = 0; m_misses = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else begin
      if (eh) m_hits++;
      if (!m_pend) begin
        if (ren && !eh) begin
          m_pend = 1; m_paddr = wa; m_misses++;
        end
      end else if (!iw) begin
        m_valid[pix] = 1; m_waddr[pix] = m_paddr; m_data[pix] = ld; m_pend = 0;
      end
      if (fl) foreach (m_valid[i]) m_valid[i] = 0;
    end
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input int waits, input logic [31:0] data, input bit fl_end);
    step(1, addr, 0, 1, 32'h0, 0);
    repeat (waits) step(1, addr, 0, 1, 32'h0, 0);
    step(1, addr, fl_end, 0, data, 0);
  endtask

  logic [31:0] raddr;
  bit          rren, rfl, riw, rrs;

  initial begin
    m_pend = 0; m_paddr = '0; m_hits = 0; m_misses = 0;
    RST = 1; imemREN = 0; imemaddr = 0; flush = 0; iwait = 1; iload = 0;
    repeat (2) @(posedge CLK);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    // Cold miss with three memory wait cycles, then replay hit.
    fill(32'h0, 3, 32'h2002_0004, 0);
    step(1, 32'h0, 0, 1, 0, 0);
    check("t1_hit",  {31'b0, last_ihit}, 32'd1);
    check("t1_load", last_load, 32'h2002_0004);
    check("t1_miss_count", miss_count, 32'd1);
    check("t1_hit_count",  hit_count, 32'd1);

    // Same-index conflict evicts and re-misses.
    step(1, 32'h0, 0, 1, 0, 0);
    fill(32'h40, 1, 32'hAAAA_0040, 0);
    step(1, 32'h40, 0, 1, 0, 0);
    fill(32'h0, 2, 32'h2002_0004, 0);
    step(1, 32'h0, 0, 1, 0, 0);
    check("t2_miss_count", miss_count, 32'd3);

    // Address redirect during fetch: fill still targets 0x10.
    step(1, 32'h10, 0, 1, 0, 0);
    step(1, 32'h20, 0, 1, 0, 0);
    step(0, 32'h20, 0, 1, 0, 0);
    step(1, 32'h20, 0, 0, 32'h1111_0010, 0);
    fill(32'h20, 0, 32'h2222_0020, 0);
    step(1, 32'h10, 0, 1, 0, 0);
    check("t3_hit10",  {31'b0, last_ihit}, 32'd1);
    check("t3_load10", last_load, 32'h1111_0010);

    // Flush coinciding with fill completion wins.
    fill(32'h8, 1, 32'h8888_0008, 1);
    step(1, 32'h8, 0, 1, 0, 0);
    check("t4_nohit", {31'b0, last_ihit}, 32'd0);
    step(1, 32'h8, 0, 0, 32'h8888_0008, 0);
    step(1, 32'h8, 1, 1, 0, 0);
    check("t4_flush_mask", {31'b0, last_ihit}, 32'd0);
    step(1, 32'h8, 0, 0, 32'h8888_0008, 0);

    // Reset in the middle of a fill.
    step(1, 32'h100, 0, 1, 0, 0);
    step(1, 32'h100, 0, 1, 0, 0);
    step(1, 32'h100, 0, 1, 0, 1);
    check("t5_hit_count", hit_count, 32'd0);
    step(0, 32'h100, 0, 1, 0, 0);
    check("t5_iren", {31'b0, last_ihit | iREN}, 32'd0);
    step(1, 32'h10, 0, 1, 0, 0);
    check("t5_miss", {31'b0, last_ihit}, 32'd0);
    step(1, 32'h10, 0, 0, 32'h5555_0010, 0);

    // Byte offset is ignored.
    fill(32'h0, 1, 32'hCAFE_F00D, 0);
    step(1, 32'h3, 0, 1, 0, 0);
    check("t6_load3", last_load, 32'hCAFE_F00D);
    step(1, 32'h0, 0, 1, 0, 0);
    check("t6_load0", last_load, 32'hCAFE_F00D);

    // Randomized traffic over a small address pool to mix hits, conflicts and fills.
    raddr = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 4)
        raddr = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      rren = ($urandom_range(0, 9) < 8);
      rfl  = ($urandom_range(0, 39) == 0);
      riw  = ($urandom_range(0, 9) < 6);
      rrs  = ($urandom_range(0, 299) == 0);
      step(rren, raddr, rfl, riw, $urandom, rrs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
